// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: instruction-memory req/ack, decode redirect and F/D valid/ready bundle
//   master: fetch unit side (drives imem request and queue head)
//   slave:  environment side (memory, decode)
interface fetch_queue_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int QDEPTH = 4
);
  localparam int CW = $clog2(QDEPTH) + 1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] pc_plus4_out;
  logic [CW-1:0] q_count;
  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_out, pc_plus4_out, q_count,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out, pc_plus4_out, q_count,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch front end with req/ack imem port, QDEPTH-entry queue and redirect flush
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imem req/addr/ack/rdata, redirect valid/pc, head valid/ready/instr/pc/pc+4, q_count
module fetch_queue_unit #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int QDEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst_n,
  fetch_queue_unit_if.master bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);
  logic [DW-1:0] data_q [QDEPTH];
  logic [AW-1:0] pcs_q [QDEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic          req_q, req_d, disc_q, disc_d;
  logic          ack, redir, push, pop, issue, head_v;
  // req_q doubles as the outstanding flag: exactly one request in flight
  always_comb begin
    head_v     = cnt_q != '0;
    redir      = bus.redirect_valid;
    ack        = req_q & bus.imem_ack;
    push       = ack & ~disc_q & ~redir;
    pop        = head_v & bus.instr_ready & ~redir;
    issue      = ~req_q & ~redir & (cnt_q != FULL);
    req_d      = issue | (req_q & ~ack);
    addr_d     = issue ? fetch_pc_q : addr_q;
    fetch_pc_d = redir ? bus.redirect_pc : push ? addr_q + AW'(4) : fetch_pc_q;
    // a redirect while waiting marks the in-flight word wrong-path; the ack clears it
    disc_d     = ~ack & (disc_q | (redir & req_q));
    wptr_d     = redir ? '0 : wptr_q + PW'(push);
    rptr_d     = redir ? '0 : rptr_q + PW'(pop);
    cnt_d      = redir ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      disc_q     <= 1'b0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      disc_q     <= disc_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wptr_q] <= bus.imem_rdata;
      pcs_q[wptr_q]  <= addr_q;
    end
  end
  // head fields read as zero while empty so reset and flushed states show clean outputs
  assign bus.imem_req     = req_q;
  assign bus.imem_addr    = addr_q;
  assign bus.instr_valid  = head_v;
  assign bus.instr_out    = head_v ? data_q[rptr_q] : '0;
  assign bus.pc_out       = head_v ? pcs_q[rptr_q] : '0;
  assign bus.pc_plus4_out = head_v ? pcs_q[rptr_q] + AW'(4) : '0;
  assign bus.q_count      = cnt_q;
endmodule
